// File: rtl/game_mode_ctrl.sv
// game_mode_ctrl: per-frame game-flow sequencer MENU -> COUNTDOWN -> FIGHT -> OVER.
// Edge-detects keys against the previous frame's keycode, latches the player
// mode at start and reports the round winner. All outputs are registered.
// Optional pause feature: define GAME_PAUSE_EN to let KEY_PAUSE freeze a fight.
module game_mode_ctrl #(
  parameter int unsigned COUNT_FRAMES = 60,
  parameter int unsigned COUNT_START  = 3,
  parameter int unsigned OVER_FRAMES  = 180,
  parameter logic [7:0]  KEY_START    = 8'h28,
  parameter logic [7:0]  KEY_BACK     = 8'h29,
  parameter logic [7:0]  KEY_PAUSE    = 8'h13
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       dual,
  input  logic       single,
  input  logic       p1_dead,
  input  logic       p2_dead,
  output logic       st,
  output logic [1:0] state,
  output logic [1:0] digit,
  output logic       fight_en,
  output logic       ai_en,
  output logic [1:0] winner,
  output logic       paused
);

`ifdef GAME_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif

  localparam logic [8:0] CD_LAST   = 9'(COUNT_FRAMES - 1);
  localparam logic [8:0] OVER_LAST = 9'(OVER_FRAMES - 1);
  localparam logic [1:0] DIGIT_1ST = 2'(COUNT_START);

  typedef enum logic [1:0] {
    S_MENU  = 2'b00,
    S_COUNT = 2'b01,
    S_FIGHT = 2'b10,
    S_OVER  = 2'b11
  } state_e;

  state_e     state_q, state_d;
  logic [8:0] fcnt_q, fcnt_d;
  logic [1:0] digit_q, digit_d;
  logic [1:0] winner_q, winner_d;
  logic [7:0] prev_key_q;
  logic       st_q, st_d;
  logic       fight_en_q, fight_en_d;
  logic       ai_en_q, ai_en_d;
  logic       paused_q, paused_d;

  // One press per key-down: the key must differ from last frame's keycode.
  logic start_p, back_p, pause_p, death;
  assign start_p = (keycode == KEY_START) && (prev_key_q != KEY_START);
  assign back_p  = (keycode == KEY_BACK)  && (prev_key_q != KEY_BACK);
  assign pause_p = PAUSE_EN && (keycode == KEY_PAUSE) && (prev_key_q != KEY_PAUSE);
  // A paused fight cannot end by death.
  assign death   = (p1_dead | p2_dead) & ~paused_q;

  // State and output registers; async active-high reset back to MENU.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= S_MENU;
      fcnt_q     <= '0;
      digit_q    <= '0;
      winner_q   <= '0;
      prev_key_q <= '0;
      st_q       <= 1'b0;
      fight_en_q <= 1'b0;
      ai_en_q    <= 1'b0;
      paused_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      digit_q    <= digit_d;
      winner_q   <= winner_d;
      prev_key_q <= keycode;
      st_q       <= st_d;
      fight_en_q <= fight_en_d;
      ai_en_q    <= ai_en_d;
      paused_q   <= paused_d;
    end
  end

  // Next-state: abort/death priorities and timer expiries.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_MENU:  if (start_p && (dual ^ single)) state_d = S_COUNT;
      S_COUNT: begin
        if (back_p)                                   state_d = S_MENU;
        else if (fcnt_q == CD_LAST && digit_q == 2'd1) state_d = S_FIGHT;
      end
      S_FIGHT: begin
        if (death)       state_d = S_OVER;
        else if (back_p) state_d = S_MENU;
      end
      S_OVER:  if (start_p || fcnt_q == OVER_LAST) state_d = S_MENU;
      default: state_d = S_MENU;
    endcase
  end

  // Next values of the registered outputs and frame counter; fcnt, digit,
  // fight_en and paused fall back to 0 whenever the state changes.
  always_comb begin
    fcnt_d     = '0;
    digit_d    = '0;
    fight_en_d = 1'b0;
    paused_d   = 1'b0;
    winner_d   = winner_q;
    ai_en_d    = ai_en_q;
    st_d       = (state_d != S_MENU);
    unique case (state_q)
      S_MENU: begin
        if (state_d == S_COUNT) begin
          ai_en_d  = single;
          winner_d = 2'b00;
          digit_d  = DIGIT_1ST;
        end
      end
      S_COUNT: begin
        if (state_d == S_FIGHT) begin
          fight_en_d = 1'b1;
        end else if (state_d == S_COUNT) begin
          if (fcnt_q == CD_LAST) begin
            digit_d = digit_q - 2'd1;
          end else begin
            fcnt_d  = fcnt_q + 9'd1;
            digit_d = digit_q;
          end
        end
      end
      S_FIGHT: begin
        if (state_d == S_OVER) begin
          // {p1_dead, p2_dead}: 01 P1 wins, 10 P2 wins, 11 draw.
          winner_d = {p1_dead, p2_dead};
        end else if (state_d == S_MENU) begin
          winner_d = 2'b00;
        end else begin
          paused_d   = paused_q ^ pause_p;
          fight_en_d = ~paused_d;
        end
      end
      S_OVER: begin
        if (state_d == S_OVER) fcnt_d = fcnt_q + 9'd1;
      end
      default: ;
    endcase
  end

  assign st       = st_q;
  assign state    = state_q;
  assign digit    = digit_q;
  assign fight_en = fight_en_q;
  assign ai_en    = ai_en_q;
  assign winner   = winner_q;
  assign paused   = paused_q;

endmodule

// File: tb/tb_game_mode_ctrl.sv
// Bench for game_mode_ctrl: directed scenarios plus random frames, all checked
// against a frame-level reference model (state + frames-since-entry).
module tb_game_mode_ctrl;
  localparam int CF = 4;
  localparam int CS = 3;
  localparam int OF = 6;
  localparam logic [7:0] K_START = 8'h28;
  localparam logic [7:0] K_BACK  = 8'h29;
  localparam logic [7:0] K_PAUSE = 8'h13;
`ifdef GAME_PAUSE_EN
  localparam bit PAUSE = 1'b1;
`else
  localparam bit PAUSE = 1'b0;
`endif

  logic       frame_clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] keycode = 8'h00;
  logic       dual = 1'b0, single = 1'b0, p1_dead = 1'b0, p2_dead = 1'b0;
  logic       st, fight_en, ai_en, paused;
  logic [1:0] state, digit, winner;

  game_mode_ctrl #(.COUNT_FRAMES(CF), .COUNT_START(CS), .OVER_FRAMES(OF)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycode(keycode), .dual(dual),
    .single(single), .p1_dead(p1_dead), .p2_dead(p2_dead), .st(st),
    .state(state), .digit(digit), .fight_en(fight_en), .ai_en(ai_en),
    .winner(winner), .paused(paused));

  always #5 frame_clk = ~frame_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: 0 MENU, 1 COUNTDOWN, 2 FIGHT, 3 OVER.
  int         m_state, m_frames;
  bit         m_ai, m_paused;
  logic [1:0] m_winner;
  logic [7:0] m_prev;

  wire [9:0] dut_v = {st, state, digit, fight_en, ai_en, winner, paused};

  function automatic logic [9:0] exp_v();
    logic [1:0] d;
    d = (m_state == 1) ? 2'(CS - m_frames / CF) : 2'd0;
    return {m_state != 0, 2'(m_state), d, (m_state == 2) && !m_paused,
            m_ai, m_winner, m_paused};
  endfunction

  task automatic model_reset();
    m_state = 0; m_frames = 0; m_ai = 0; m_paused = 0; m_winner = 2'b00; m_prev = 8'h00;
  endtask

  task automatic go(input int s);
    m_state = s; m_frames = 0; m_paused = 0;
  endtask

  task automatic model_step();
    bit ps, pb, pp;
    ps = (keycode == K_START) && (m_prev != K_START);
    pb = (keycode == K_BACK)  && (m_prev != K_BACK);
    pp = PAUSE && (keycode == K_PAUSE) && (m_prev != K_PAUSE);
    case (m_state)
      0: if (ps && (dual != single)) begin
           m_ai = single; m_winner = 2'b00; go(1);
         end
      1: if (pb) go(0);
         else begin
           m_frames++;
           if (m_frames == CS * CF) go(2);
         end
      2: if (!m_paused && (p1_dead || p2_dead)) begin
           if (p1_dead && p2_dead) m_winner = 2'b11;
           else if (p2_dead)       m_winner = 2'b01;
           else                    m_winner = 2'b10;
           go(3);
         end else if (pb) begin
           m_winner = 2'b00; go(0);
         end else if (pp) m_paused = !m_paused;
      default: if (ps) go(0);
         else begin
           m_frames++;
           if (m_frames == OF) go(0);
         end
    endcase
    m_prev = keycode;
  endtask

  // Apply one frame of inputs, clock it, advance the model, settle.
  task automatic drive(input logic [7:0] k, input bit d, input bit s, input bit a, input bit b);
    keycode = k; dual = d; single = s; p1_dead = a; p2_dead = b;
    @(posedge frame_clk);
    model_step();
    #1;
  endtask

  task automatic go_fight(input bit d, input bit s);
    drive(8'h00, d, s, 0, 0);
    drive(K_START, d, s, 0, 0);
    repeat (CS * CF) drive(8'h00, d, s, 0, 0);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    model_reset();
    repeat (2) @(posedge frame_clk);
    #1;
    n_cmp++;
    if (dut_v !== 10'b0) begin
      n_bad++; $display("FAIL reset_values: got %b want %b", dut_v, 10'b0);
    end
    @(negedge frame_clk);
    Reset = 1'b0;
    drive(8'h00, 0, 0, 0, 0);
    n_cmp++;
    if (dut_v !== exp_v()) begin
      n_bad++; $display("FAIL reset_idle: got %b want %b", dut_v, exp_v());
    end
  endtask

  task automatic test_start_held();
    drive(8'h00, 0, 1, 0, 0);
    drive(K_START, 0, 1, 0, 0);
    n_cmp++;
    if ({st, state, digit, ai_en} !== {1'b1, 2'b01, 2'd3, 1'b1}) begin
      n_bad++; $display("FAIL start_edge: got %b want %b", {st, state, digit, ai_en}, 6'b101111);
    end
    for (int i = 0; i < 4; i++) begin
      drive(K_START, 0, 1, 0, 0);
      n_cmp++;
      if (dut_v !== exp_v() || state !== 2'b01) begin
        n_bad++; $display("FAIL start_held f%0d: got %b want %b", i, dut_v, exp_v());
      end
    end
  endtask

  task automatic test_countdown();
    drive(K_BACK, 0, 1, 0, 0);
    n_cmp++;
    if ({st, state} !== 3'b000 || dut_v !== exp_v()) begin
      n_bad++; $display("FAIL back_in_countdown: got %b want %b", dut_v, exp_v());
    end
    drive(8'h00, 1, 0, 0, 0);
    drive(K_START, 1, 0, 0, 0);
    for (int k = 1; k <= CS * CF; k++) begin
      logic [4:0] want;
      drive(8'h00, 1, 0, 0, 0);
      want = (k < CS * CF) ? {2'b01, 2'(CS - k / CF), 1'b0} : {2'b10, 2'd0, 1'b1};
      n_cmp++;
      if ({state, digit, fight_en} !== want || dut_v !== exp_v()) begin
        n_bad++; $display("FAIL countdown k%0d: got %b want %b", k, {state, digit, fight_en}, want);
      end
    end
  endtask

  task automatic test_draw_over();
    drive(8'h00, 1, 0, 1, 1);
    n_cmp++;
    if ({state, winner, fight_en} !== 5'b11110 || dut_v !== exp_v()) begin
      n_bad++; $display("FAIL draw_edge: got %b want %b", dut_v, exp_v());
    end
    for (int i = 1; i <= OF; i++) begin
      drive(8'h00, 1, 0, 0, 0);
      n_cmp++;
      if (dut_v !== exp_v()) begin
        n_bad++; $display("FAIL over_hold f%0d: got %b want %b", i, dut_v, exp_v());
      end
    end
    n_cmp++;
    if ({st, state, winner} !== 5'b00011) begin
      n_bad++; $display("FAIL over_end: got %b want %b", {st, state, winner}, 5'b00011);
    end
  endtask

  task automatic test_menu_invalid();
    drive(8'h00, 1, 1, 0, 0);
    drive(K_START, 1, 1, 0, 0);
    n_cmp++;
    if ({st, state} !== 3'b000 || dut_v !== exp_v()) begin
      n_bad++; $display("FAIL menu_both_sel: got %b want %b", dut_v, exp_v());
    end
    drive(8'h00, 0, 0, 0, 0);
    drive(K_START, 0, 0, 0, 0);
    n_cmp++;
    if ({st, state} !== 3'b000 || dut_v !== exp_v()) begin
      n_bad++; $display("FAIL menu_none_sel: got %b want %b", dut_v, exp_v());
    end
  endtask

  task automatic test_over_skip();
    go_fight(1, 0);
    drive(8'h00, 1, 0, 0, 1);
    n_cmp++;
    if ({state, winner, ai_en} !== 5'b11010 || dut_v !== exp_v()) begin
      n_bad++; $display("FAIL p1_wins: got %b want %b", dut_v, exp_v());
    end
    drive(K_START, 1, 0, 0, 0);
    n_cmp++;
    if ({state, winner} !== 4'b0001 || dut_v !== exp_v()) begin
      n_bad++; $display("FAIL over_skip: got %b want %b", dut_v, exp_v());
    end
    drive(K_START, 1, 0, 0, 0);
    n_cmp++;
    if (state !== 2'b00 || dut_v !== exp_v()) begin
      n_bad++; $display("FAIL held_no_restart: got %b want %b", dut_v, exp_v());
    end
  endtask

  task automatic test_back_fight();
    go_fight(0, 1);
    drive(K_BACK, 0, 1, 1, 0);
    n_cmp++;
    if ({state, winner} !== 4'b1110 || dut_v !== exp_v()) begin
      n_bad++; $display("FAIL death_over_back: got %b want %b", dut_v, exp_v());
    end
    drive(K_START, 0, 1, 0, 0);
    go_fight(0, 1);
    drive(K_BACK, 0, 1, 0, 0);
    n_cmp++;
    if ({st, state, winner, fight_en} !== 6'b000000 || dut_v !== exp_v()) begin
      n_bad++; $display("FAIL back_in_fight: got %b want %b", dut_v, exp_v());
    end
  endtask

  task automatic test_async_reset();
    go_fight(1, 0);
    #3 Reset = 1'b1;
    #1;
    model_reset();
    n_cmp++;
    if (dut_v !== 10'b0) begin
      n_bad++; $display("FAIL async_reset: got %b want %b", dut_v, 10'b0);
    end
    #1 Reset = 1'b0;
    keycode = 8'h00;
    drive(8'h00, 1, 0, 0, 0);
    n_cmp++;
    if (dut_v !== exp_v()) begin
      n_bad++; $display("FAIL after_reset: got %b want %b", dut_v, exp_v());
    end
  endtask

  task automatic test_pause();
    go_fight(1, 0);
    drive(K_PAUSE, 1, 0, 0, 0);
    n_cmp++;
    if ({paused, fight_en} !== {PAUSE, !PAUSE} || dut_v !== exp_v()) begin
      n_bad++; $display("FAIL pause_press: got %b want %b", dut_v, exp_v());
    end
    if (PAUSE) begin
      drive(8'h00, 1, 0, 0, 1);
      n_cmp++;
      if (state !== 2'b10 || dut_v !== exp_v()) begin
        n_bad++; $display("FAIL paused_no_death: got %b want %b", dut_v, exp_v());
      end
      drive(K_PAUSE, 1, 0, 0, 1);
      n_cmp++;
      if ({state, paused} !== 3'b100 || dut_v !== exp_v()) begin
        n_bad++; $display("FAIL unpause: got %b want %b", dut_v, exp_v());
      end
      drive(8'h00, 1, 0, 0, 1);
      n_cmp++;
      if ({state, winner} !== 4'b1101 || dut_v !== exp_v()) begin
        n_bad++; $display("FAIL unpaused_death: got %b want %b", dut_v, exp_v());
      end
    end else begin
      drive(8'h00, 1, 0, 0, 1);
    end
  endtask

  task automatic test_random();
    logic [7:0] k;
    k = 8'h00;
    for (int i = 0; i < 800; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r <= 3)      k = 8'h00;
      else if (r <= 5) k = K_START;
      else if (r == 6) k = K_BACK;
      else if (r == 7) k = K_PAUSE;
      else if (r == 9) k = 8'($urandom);
      drive(k, 1'($urandom), 1'($urandom),
            $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
      n_cmp++;
      if (dut_v !== exp_v()) begin
        n_bad++; $display("FAIL random f%0d key %h: got %b want %b", i, k, dut_v, exp_v());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_start_held();
    test_countdown();
    test_draw_over();
    test_menu_invalid();
    test_over_skip();
    test_back_fight();
    test_async_reset();
    test_pause();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_mode_ctrl.md
# game_mode_ctrl

Game-flow sequencer that consumes the menu selection (`dual` / `single`) and keyboard `keycode`, and drives the start flag `st` back to the menu cursor logic. Once `st` is high, the menu freezes its selection. The block runs the menu → countdown → fight → game-over sequence, one step per video frame. It latches single-player mode as `ai_en` and reports the round winner to the renderer.

## Interface
Parameters:
- `COUNT_FRAMES`, default 60: frames per countdown digit; legal range 1..511.
- `COUNT_START`, default 3: first countdown digit; legal range 1..3.
- `OVER_FRAMES`, default 180: frames the result screen is held; legal range 1..511.
- `KEY_START`, default 8'h28: start/confirm keycode (Enter).
- `KEY_BACK`, default 8'h29: abort keycode (Esc).
- `KEY_PAUSE`, default 8'h13: pause keycode (P); used only with `GAME_PAUSE_EN`.

Ports:
- `frame_clk` in 1: frame clock (vsync rate).
- `Reset` in 1: asynchronous, active-high reset.
- `keycode` in 8: current keyboard keycode; 8'h00 means no key.
- `dual` in 1: two-player mode selected.
- `single` in 1: one-player mode selected.
- `p1_dead` in 1: player 1 health has reached zero.
- `p2_dead` in 1: player 2 health has reached zero.
- `st` out 1: game started; high in every state except MENU.
- `state` out 2: 00 MENU, 01 COUNTDOWN, 10 FIGHT, 11 OVER.
- `digit` out 2: countdown digit to display; 0 outside COUNTDOWN.
- `fight_en` out 1: player movement and attacks enabled.
- `ai_en` out 1: player 2 is CPU-controlled; latched at start.
- `winner` out 2: 00 none, 01 P1 wins, 10 P2 wins, 11 draw.
- `paused` out 1: fight is paused.

## Operation
- Key press detection:
  - `prev_key` is an 8-bit register that loads `keycode` every frame.
  - press(K) is true when `keycode`==K and `prev_key`!=K.
  - A held key produces exactly one press.
- MENU:
  - On press(KEY_START) with `dual`^`single`==1: set `ai_en`=`single`, clear `winner`, set `digit`=COUNT_START, clear `fcnt`, go to COUNTDOWN.
  - If `dual` and `single` are both 0 or both 1, the press is ignored.
- COUNTDOWN:
  - `fcnt` increments every frame.
  - When `fcnt`==COUNT_FRAMES-1: `fcnt` returns to 0 and `digit` decrements.
  - If `digit` is 1 at that point: go to FIGHT, `digit`=0, `fight_en`=1.
  - press(KEY_BACK) returns to MENU and has priority over the countdown step.
- FIGHT:
  - Both dead: `winner`=11. Only `p2_dead`: 01. Only `p1_dead`: 10.
  - Any death takes the block to OVER with `fight_en`=0 and `fcnt`=0.
  - press(KEY_BACK) returns to MENU with `winner`=00; death has priority over BACK in the same frame.
- OVER:
  - `fcnt` counts up; at `fcnt`==OVER_FRAMES-1 go to MENU.
  - press(KEY_START) goes to MENU early.
  - `winner` is held through MENU until the next start.
- `ai_en` is held until the next accepted start.
- `fcnt` is 9 bits unsigned and is cleared on every state change.

## Timing
- All outputs are registered. A response appears on the frame_clk edge that samples the triggering input, i.e. one frame of latency.
- Reset values: `state`=MENU, `st`=0, `digit`=0, `fight_en`=0, `ai_en`=0, `winner`=00, `paused`=0, `fcnt`=0, `prev_key`=8'h00.
- Reset asserted mid-round takes effect immediately (asynchronous) and the block returns to MENU.
- COUNTDOWN length: exactly COUNT_START×COUNT_FRAMES frames from the MENU→COUNTDOWN edge to the FIGHT edge.
- OVER length: exactly OVER_FRAMES frames unless skipped by KEY_START.
- `st` rises on the same edge as the MENU→COUNTDOWN transition and falls on the edge entering MENU.

## Configuration
- `GAME_PAUSE_EN` defined:
  - In FIGHT, press(KEY_PAUSE) toggles `paused`.
  - While paused: `fight_en`=0, `p1_dead`/`p2_dead` are ignored, KEY_BACK still aborts.
  - `paused` is cleared on any exit from FIGHT.
- `GAME_PAUSE_EN` undefined:
  - `paused` is tied to 0 and KEY_PAUSE is ignored.
  - All other behaviour is identical.

## Test plan
- Reset, then `single`=1, `dual`=0, `keycode` 00→28 held 5 frames:
  - After one edge: `st`=1, `state`=01, `digit`=3, `ai_en`=1.
  - Exactly one transition occurs while the key is held.
- COUNT_FRAMES=4, COUNT_START=3, started: `digit` reads 3,2,1 for 4 frames each; `state`=10 and `fight_en`=1 exactly 12 frames after start.
- In FIGHT, `p1_dead`=`p2_dead`=1 on the same frame: next edge gives `state`=11, `winner`=11, `fight_en`=0. After OVER_FRAMES frames: `state`=00, `st`=0, `winner` still 11.
- In MENU with `dual`=`single`=1, press 28: no state change and `st` stays 0. In COUNTDOWN, press 29: `state`=00, `st`=0.
- Pulse Reset mid-FIGHT between clock edges: outputs go to reset values immediately, before the next frame_clk edge.
- `GAME_PAUSE_EN` defined, FIGHT, press 13 then assert `p2_dead`: `paused`=1, `fight_en`=0, no transition. Press 13 again: `paused`=0, and the next edge gives `winner`=01.
